// File: rtl/mandelbrot_pkg.sv
// Shared fixed-point format and scheduler state encoding for the Mandelbrot pipeline.
// The engine imports this package too, so both sides agree on the coordinate format.
package mandelbrot_pkg;

  localparam int unsigned FpTop  = 8;
  localparam int unsigned FpBot  = 24;
  localparam int unsigned FpBits = FpTop + FpBot;

  typedef logic signed [FpBits-1:0] fp_t;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StEmit,
    StDone
  } sched_state_e;

endpackage

// File: rtl/mandelbrot_scheduler_if.sv
// Valid/ready pixel result stream from the scheduler toward the framebuffer writer.
interface mandelbrot_scheduler_if #(
  parameter int unsigned AddrW = 19
);
  logic             pix_valid;
  logic             pix_ready;
  logic [AddrW-1:0] pix_addr;
  logic [31:0]      pix_iter;

  modport master (output pix_valid, output pix_addr, output pix_iter, input pix_ready);
  modport slave  (input pix_valid, input pix_addr, input pix_iter, output pix_ready);
endinterface

// File: rtl/raster_counter.sv
// Raster-order grid walker: column/row counters plus a linear pixel address counter,
// so the scheduler never needs a row*WIDTH multiplier.
module raster_counter #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter int unsigned AddrW  = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic             row_end,
  output logic             last,
  output logic [AddrW-1:0] addr
);
  localparam int unsigned ColW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned RowW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [ColW-1:0]  col_q, col_d;
  logic [RowW-1:0]  row_q, row_d;
  logic [AddrW-1:0] addr_q, addr_d;

  assign row_end = (col_q == ColW'(WIDTH - 1));
  assign last    = row_end && (row_q == RowW'(HEIGHT - 1));
  assign addr    = addr_q;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (clear) begin
      col_d  = '0;
      row_d  = '0;
      addr_d = '0;
    end else if (advance && !last) begin
      // The final pixel stays put; the next start clears everything anyway.
      addr_d = addr_q + 1'b1;
      if (row_end) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/mandelbrot_scheduler.sv
// Frame scheduler: walks the pixel grid, launches the engine once per pixel via its reset,
// and streams each iteration count out on a valid/ready interface.
module mandelbrot_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int unsigned fp_top = FpTop,
  parameter int unsigned fp_bot = FpBot,
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  localparam int unsigned FpW   = fp_top + fp_bot,
  localparam int unsigned AddrW = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [FpW-1:0] x_start,
  input  logic signed [FpW-1:0] y_start,
  input  logic signed [FpW-1:0] step,
  input  logic [31:0]           iterations_max,
  output logic                  eng_reset,
  output logic signed [FpW-1:0] eng_x0,
  output logic signed [FpW-1:0] eng_y0,
  output logic [31:0]           eng_iterations_max,
  input  logic                  eng_finished,
  input  logic [31:0]           eng_iterations,
  mandelbrot_scheduler_if.master pix,
  output logic                  busy,
  output logic                  done
);
  sched_state_e state_q, state_d;

  logic signed [FpW-1:0] x0_q, x0_d, y0_q, y0_d, xs_q, xs_d, step_q, step_d;
  logic [31:0]           itmax_q, itmax_d, iter_q, iter_d;
  logic                  clear, advance, row_end, last;
  logic [AddrW-1:0]      addr;

  raster_counter #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .AddrW (AddrW)
  ) u_raster (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .advance(advance),
    .row_end(row_end),
    .last   (last),
    .addr   (addr)
  );

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    xs_d    = xs_q;
    step_d  = step_q;
    itmax_d = itmax_q;
    iter_d  = iter_q;
    clear   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          xs_d    = x_start;
          step_d  = step;
          itmax_d = iterations_max;
          x0_d    = x_start;
          y0_d    = y_start;
          clear   = 1'b1;
          state_d = StLaunch;
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (eng_finished) begin
          iter_d  = eng_iterations;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (pix.pix_ready) begin
          advance = 1'b1;
          if (last) begin
            state_d = StDone;
          end else begin
            state_d = StLaunch;
            // Imaginary axis runs downward, so a new row subtracts the step.
            if (row_end) begin
              x0_d = xs_q;
              y0_d = y0_q - step_q;
            end else begin
              x0_d = x0_q + step_q;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      x0_q    <= '0;
      y0_q    <= '0;
      xs_q    <= '0;
      step_q  <= '0;
      itmax_q <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      xs_q    <= xs_d;
      step_q  <= step_d;
      itmax_q <= itmax_d;
      iter_q  <= iter_d;
    end
  end

  // Engine stays parked in reset everywhere except while it is computing.
  assign eng_reset          = (state_q != StWait);
  assign eng_x0             = x0_q;
  assign eng_y0             = y0_q;
  assign eng_iterations_max = itmax_q;
  assign pix.pix_valid      = (state_q == StEmit);
  assign pix.pix_addr       = addr;
  assign pix.pix_iter       = iter_q;
  assign busy               = (state_q != StIdle);
  assign done               = (state_q == StDone);

endmodule
